// File: rtl/shift_counter_gen.sv
// Run-time selectable one-hot ring / Johnson sequencer with direction, enable, load and wrap pulse.
// Optional build macro SHIFT_COUNTER_SELF_CORRECT_EN: an enabled step from an illegal state returns to HOME.
module shift_counter_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] HOME = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] step_val;
  int unsigned      ones;
  int unsigned      edges;

  // Ring needs exactly one hot bit; Johnson allows at most one 0/1 boundary along the word.
  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (q[i]) ones++;
    end
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (q[i] != q[i+1]) edges++;
    end
    illegal = mode ? (edges > 1) : (ones != 1);
  end

  always_comb begin
    step_val = q;
    unique case ({mode, dir})
      2'b01:   step_val = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b00:   step_val = {q[0], q[WIDTH-1:1]};
      2'b11:   step_val = {q[WIDTH-2:0], ~q[WIDTH-1]};
      2'b10:   step_val = {~q[0], q[WIDTH-1:1]};
      default: step_val = q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= HOME;
      tc <= 1'b0;
    end else if (load) begin
      q  <= load_val;
      tc <= 1'b0;
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    end else if (en && illegal) begin
      q  <= HOME;
      tc <= 1'b0;
`endif
    end else if (en) begin
      q  <= step_val;
      tc <= (step_val == HOME);
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Self-checking bench for shift_counter_gen: directed sequences plus randomized stimulus
// checked against a behavioural model built on shifts, masks and popcounts.
module tb_shift_counter_gen;

  localparam int W = 4;
  localparam bit [W-1:0] HOME = 4'b0001;
  localparam bit [W-1:0] MASK = 4'b1111;
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         illegal;

  bit [W-1:0] mq;
  bit         mtc;
  int         errors = 0;
  int         checks = 0;

  shift_counter_gen #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic bit legal(bit [W-1:0] v, bit m);
    bit [W-1:0] d;
    d = (v ^ (v >> 1)) & (MASK >> 1);
    if (!m) return $countones(v) == 1;
    return $countones(d) <= 1;
  endfunction

  // Ring rotates the bit that falls off back in; Johnson feeds back its complement.
  function automatic bit [W-1:0] shifted(bit [W-1:0] v, bit m, bit up);
    bit [W-1:0] f;
    bit         fill;
    f = '0;
    if (up) begin
      fill = m ? ~v[W-1] : v[W-1];
      return ((v << 1) & MASK) | {{(W-1){1'b0}}, fill};
    end
    fill = m ? ~v[0] : v[0];
    f[W-1] = fill;
    return (v >> 1) | f;
  endfunction

  task automatic check(string tag);
    bit exp_ill;
    exp_ill = !legal(mq, mode);
    checks++;
    assert (q === mq) else begin
      errors++;
      $error("FAIL %s q: got %b want %b", tag, q, mq);
    end
    checks++;
    assert (tc === mtc) else begin
      errors++;
      $error("FAIL %s tc: got %b want %b", tag, tc, mtc);
    end
    checks++;
    assert (illegal === exp_ill) else begin
      errors++;
      $error("FAIL %s illegal: got %b want %b", tag, illegal, exp_ill);
    end
  endtask

  task automatic check_q(string tag, bit [W-1:0] want);
    checks++;
    assert (q === want) else begin
      errors++;
      $error("FAIL %s q_const: got %b want %b", tag, q, want);
    end
  endtask

  // Apply one rising edge with the current inputs, update the model, then check.
  task automatic step(string tag);
    if (load) begin
      mq  = load_val;
      mtc = 1'b0;
    end else if (en && CORR && !legal(mq, mode)) begin
      mq  = HOME;
      mtc = 1'b0;
    end else if (en) begin
      mq  = shifted(mq, mode, dir);
      mtc = (mq == HOME);
    end else begin
      mtc = 1'b0;
    end
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    bit [W-1:0] ring_up [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit [W-1:0] john_up [8]  = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    bit [W-1:0] ring_dn [4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    mq  = HOME;
    mtc = 1'b0;
    #10 reset = 1'b0;
    #1 check("reset");
    check_q("reset", HOME);

    en = 1'b1; dir = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("ring_up");
      check_q("ring_up", ring_up[i]);
    end

    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("johnson_up");
      check_q("johnson_up", john_up[i]);
    end

    mode = 1'b0; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("ring_down");
      check_q("ring_down", ring_dn[i]);
    end
    step("ring_down2");
    step("ring_down3");
    check_q("ring_down3", 4'b0100);
    dir = 1'b1;
    step("dir_flip");
    check_q("dir_flip", 4'b1000);
    dir = 1'b0;
    step("back_down");

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check_q("hold", 4'b0100);
    end

    en = 1'b1; load = 1'b1; load_val = 4'b0010;
    step("load_over_en");
    check_q("load_over_en", 4'b0010);

    load_val = 4'b0101; dir = 1'b1;
    step("load_illegal");
    load = 1'b0;
    step("illegal_step");
    check_q("illegal_step", CORR ? 4'b0001 : 4'b1010);

    // Asynchronous reset landing between edges.
    en = 1'b0; load = 1'b1; load_val = 4'b0100;
    step("pre_async");
    load = 1'b0; mode = 1'b1; en = 1'b1;
    #2 reset = 1'b1;
    mq  = HOME;
    mtc = 1'b0;
    #1 check("async_reset");
    check_q("async_reset", HOME);
    #1 reset = 1'b0;
    step("post_reset");
    check_q("post_reset", 4'b0011);

    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      dir      = ($urandom_range(0, 7) != 0) ? dir : ~dir;
      mode     = ($urandom_range(0, 15) != 0) ? mode : ~mode;
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
